// File: rtl/shift_pipe_pkg.sv
// Shared definitions for the pipelined barrel shifter: mode encodings and
// small helpers used at elaboration time and in the datapath.
package shift_pipe_pkg;

   localparam logic [2:0] SH_SLL = 3'b000;
   localparam logic [2:0] SH_SRL = 3'b001;
   localparam logic [2:0] SH_SRA = 3'b010;
   localparam logic [2:0] SH_ROL = 3'b011;
   localparam logic [2:0] SH_ROR = 3'b100;

   function automatic int clog2(input int value);
      int res;
      res = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) res = i + 1;
      end
      return res;
   endfunction

   // Right modes run through the left network on a bit-reversed operand.
   function automatic logic is_right(input logic [2:0] mode);
      return (mode == SH_SRL) || (mode == SH_SRA) || (mode == SH_ROR);
   endfunction

   function automatic logic is_rot(input logic [2:0] mode);
      return (mode == SH_ROL) || (mode == SH_ROR);
   endfunction

   function automatic logic is_pass(input logic [2:0] mode);
      return mode > SH_ROR;
   endfunction

endpackage

// File: rtl/mux_2.sv
// Generic two-input multiplexer, sel=1 picks b.
module mux_2 #(
   parameter int W = 8
) (
   input  logic         sel,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] y
);

   assign y = sel ? b : a;

endmodule

// File: rtl/shift_stage.sv
// One log-shifter stage: optionally shifts left by AMOUNT, filling the
// vacated low bits from the fill input.
module shift_stage #(
   parameter int WIDTH  = 32,
   parameter int AMOUNT = 1
) (
   input  logic              en,
   input  logic [WIDTH-1:0]  din,
   input  logic [AMOUNT-1:0] fill,
   output logic [WIDTH-1:0]  dout
);

   logic [WIDTH-1:0] shifted;

   assign shifted = {din[WIDTH-AMOUNT-1:0], fill};

   mux_2 #(.W(WIDTH)) u_mux (
      .sel (en),
      .a   (din),
      .b   (shifted),
      .y   (dout)
   );

endmodule

// File: rtl/shift_pipe.sv
// Elastic pipelined barrel shifter: SHW log stages with a register bank
// after every REG_EVERY stages and after the last one.
module shift_pipe
   import shift_pipe_pkg::*;
#(
   parameter int  WIDTH     = 32,
   parameter int  REG_EVERY = 2,
   parameter int  TAGW      = 5,
   localparam int SHW       = clog2(WIDTH),
   localparam int L         = (SHW + REG_EVERY - 1) / REG_EVERY
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [SHW-1:0]   in_shamt,
   input  logic [2:0]       in_mode,
   input  logic [TAGW-1:0]  in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [TAGW-1:0]  out_tag
);

   logic [L-1:0]     vld_q, vld_d, adv;
   logic [WIDTH-1:0] data_q [L];
   logic [WIDTH-1:0] data_d [L];
   logic [SHW-1:0]   shamt_q [L];
   logic [SHW-1:0]   shamt_d [L];
   logic [2:0]       mode_q [L];
   logic [2:0]       mode_d [L];
   logic [L-1:0]     sign_q, sign_d;
   logic [TAGW-1:0]  tag_q [L];
   logic [TAGW-1:0]  tag_d [L];

   // Segment sources: index 0 is the input port, index j is bank j-1.
   logic [L-1:0]     src_vld;
   logic [WIDTH-1:0] src_data [L];
   logic [SHW-1:0]   src_shamt [L];
   logic [2:0]       src_mode [L];
   logic [L-1:0]     src_sign;
   logic [TAGW-1:0]  src_tag [L];

   logic [WIDTH-1:0] stg_out [SHW];
   logic [WIDTH-1:0] bank_in [L];
   logic [WIDTH-1:0] rev_in, rev_out;
   logic             adv_chain;
   logic             unused_bits;

   always_comb begin : src_sel
      rev_in       = {<<{in_data}};
      src_vld[0]   = in_valid;
      src_data[0]  = is_right(in_mode) ? rev_in : in_data;
      src_shamt[0] = is_pass(in_mode) ? '0 : in_shamt;
      src_mode[0]  = in_mode;
      src_sign[0]  = in_data[WIDTH-1];
      src_tag[0]   = in_tag;
      for (int j = 1; j < L; j++) begin
         src_vld[j]   = vld_q[j-1];
         src_data[j]  = data_q[j-1];
         src_shamt[j] = shamt_q[j-1];
         src_mode[j]  = mode_q[j-1];
         src_sign[j]  = sign_q[j-1];
         src_tag[j]   = tag_q[j-1];
      end
   end

   for (genvar k = 0; k < SHW; k++) begin : g_stg
      localparam int B   = k / REG_EVERY;
      localparam int AMT = 1 << k;
      logic [WIDTH-1:0] din;
      logic [AMT-1:0]   fill;
      logic             fbit;

      if (k % REG_EVERY == 0) begin : g_head
         assign din = src_data[B];
      end else begin : g_body
         assign din = stg_out[k-1];
      end

      // Rotates recirculate the bits leaving the top; SRA fills with the sign.
      assign fbit = (src_mode[B] == SH_SRA) & src_sign[B];
      assign fill = is_rot(src_mode[B]) ? din[WIDTH-1 -: AMT] : {AMT{fbit}};

      shift_stage #(.WIDTH(WIDTH), .AMOUNT(AMT)) u_stage (
         .en   (src_shamt[B][k]),
         .din  (din),
         .fill (fill),
         .dout (stg_out[k])
      );
   end

   for (genvar j = 0; j < L; j++) begin : g_bank
      localparam int LAST = (((j + 1) * REG_EVERY < SHW) ? (j + 1) * REG_EVERY : SHW) - 1;
      assign bank_in[j] = stg_out[LAST];
   end

   always_comb begin : nxt
      adv_chain  = ~vld_q[L-1] | out_ready;
      adv[L-1]   = adv_chain;
      for (int i = L - 2; i >= 0; i--) begin
         adv_chain = ~vld_q[i] | adv_chain;
         adv[i]    = adv_chain;
      end
      vld_d   = vld_q;
      data_d  = data_q;
      shamt_d = shamt_q;
      mode_d  = mode_q;
      sign_d  = sign_q;
      tag_d   = tag_q;
      for (int i = 0; i < L; i++) begin
         if (adv[i]) begin
            vld_d[i]   = src_vld[i];
            data_d[i]  = bank_in[i];
            shamt_d[i] = src_shamt[i];
            mode_d[i]  = src_mode[i];
            sign_d[i]  = src_sign[i];
            tag_d[i]   = src_tag[i];
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         vld_q  <= '0;
         sign_q <= '0;
         for (int i = 0; i < L; i++) begin
            data_q[i]  <= '0;
            shamt_q[i] <= '0;
            mode_q[i]  <= SH_SLL;
            tag_q[i]   <= '0;
         end
      end else begin
         vld_q  <= vld_d;
         sign_q <= sign_d;
         for (int i = 0; i < L; i++) begin
            data_q[i]  <= data_d[i];
            shamt_q[i] <= shamt_d[i];
            mode_q[i]  <= mode_d[i];
            tag_q[i]   <= tag_d[i];
         end
      end
   end

   always_comb begin : outs
      rev_out  = {<<{data_q[L-1]}};
      out_data = is_right(mode_q[L-1]) ? rev_out : data_q[L-1];
   end

   assign out_valid = vld_q[L-1];
   assign out_tag   = tag_q[L-1];
   assign in_ready  = adv[0];

   // Shift bits already consumed and the last bank's sign are dead by design.
   always_comb begin : sink
      unused_bits = sign_q[L-1] ^ (^shamt_q[L-1]);
      for (int j = 0; j < L; j++) unused_bits = unused_bits ^ (^src_shamt[j]);
   end

endmodule

// File: tb/tb_shift_pipe.sv
// Bench for shift_pipe: directed mode/edge/elasticity cases plus random
// traffic against an arithmetic reference model and an in-order scoreboard.
module tb_shift_pipe;

   localparam int WIDTH = 32;
   localparam int TAGW  = 5;
   localparam int SHW   = 5;
   localparam int L     = 3;

   logic             clock = 1'b0;
   logic             reset_n;
   logic             in_valid, in_ready;
   logic [WIDTH-1:0] in_data;
   logic [SHW-1:0]   in_shamt;
   logic [2:0]       in_mode;
   logic [TAGW-1:0]  in_tag;
   logic             out_valid, out_ready;
   logic [WIDTH-1:0] out_data;
   logic [TAGW-1:0]  out_tag;

   int n_chk = 0;
   int n_err = 0;

   typedef struct {
      logic [WIDTH-1:0] d;
      logic [TAGW-1:0]  t;
   } exp_t;
   exp_t sb[$];

   logic             held;
   logic [WIDTH-1:0] held_d;
   logic [TAGW-1:0]  held_t;
   logic [TAGW-1:0]  tag_ctr;

   shift_pipe #(.WIDTH(WIDTH), .REG_EVERY(2), .TAGW(TAGW)) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_shamt  (in_shamt),
      .in_mode   (in_mode),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_tag   (out_tag)
   );

   always #5 clock = ~clock;

   task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h expected %08h", name, got, exp);
      end
   endtask

   function automatic logic [31:0] ref_shift(input logic [31:0] a, input logic [4:0] s,
                                             input logic [2:0] m);
      logic [5:0] inv;
      inv = 6'd32 - {1'b0, s};
      case (m)
         3'd0:    return a << s;
         3'd1:    return a >> s;
         3'd2:    return $signed(a) >>> s;
         3'd3:    return (a << s) | (a >> inv);
         3'd4:    return (a >> s) | (a << inv);
         default: return a;
      endcase
   endfunction

   always @(negedge clock) begin
      exp_t e;
      if (!reset_n) begin
         held = 1'b0;
      end else begin
         if (held) begin
            check_val("stall_valid", 32'(out_valid), 32'd1);
            check_val("stall_data", out_data, held_d);
            check_val("stall_tag", 32'(out_tag), 32'(held_t));
         end
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               check_val("unexpected_out", 32'(out_tag), 32'hFFFF_FFFF);
            end else begin
               e = sb.pop_front();
               check_val("sb_data", out_data, e.d);
               check_val("sb_tag", 32'(out_tag), 32'(e.t));
            end
         end
         if (in_valid && in_ready)
            sb.push_back('{d: ref_shift(in_data, in_shamt, in_mode), t: in_tag});
         held   = out_valid && !out_ready;
         held_d = out_data;
         held_t = out_tag;
      end
   end

   task automatic run_one(input logic [31:0] a, input logic [4:0] s, input logic [2:0] m,
                          input logic [31:0] exp, input string name);
      int n;
      in_valid  = 1'b1;
      in_data   = a;
      in_shamt  = s;
      in_mode   = m;
      in_tag    = tag_ctr;
      out_ready = 1'b1;
      @(negedge clock);
      check_val({name, "_rdy"}, 32'(in_ready), 32'd1);
      @(posedge clock);
      #1 in_valid = 1'b0;
      tag_ctr++;
      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (!out_valid && n < 20);
      check_val({name, "_lat"}, 32'(n), 32'(L));
      check_val(name, out_data, exp);
      @(posedge clock);
      #1;
   endtask

   task automatic drain();
      int cnt;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      cnt = 0;
      while ((sb.size() != 0 || out_valid) && cnt < 50) begin
         @(posedge clock);
         #1 cnt++;
      end
      check_val("drain", 32'(sb.size()), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0]  modes [6];
      logic [31:0] exps  [6];
      logic [31:0] a;
      int          acc, cnt, extra;
      logic        fire;

      modes = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd7};
      exps  = '{32'h0000_0F10, 32'h0800_000F, 32'hF800_000F,
                32'h0000_0F18, 32'h1800_000F, 32'h8000_00F1};
      tag_ctr = '0;
      held    = 1'b0;

      // reset with an operand offered
      reset_n   = 1'b0;
      in_valid  = 1'b1;
      in_data   = 32'hDEAD_BEEF;
      in_shamt  = 5'd3;
      in_mode   = 3'd0;
      in_tag    = 5'd9;
      out_ready = 1'b1;
      #12;
      check_val("rst_out_valid", 32'(out_valid), 32'd0);
      check_val("rst_out_data", out_data, 32'd0);
      check_val("rst_out_tag", 32'(out_tag), 32'd0);
      check_val("rst_in_ready", 32'(in_ready), 32'd1);
      @(posedge clock);
      #1 reset_n = 1'b1;
      in_valid = 1'b0;
      check_val("post_rst_in_ready", 32'(in_ready), 32'd1);
      check_val("rst_no_xfer", 32'(sb.size()), 32'd0);
      @(posedge clock);
      #1;

      for (int i = 0; i < 6; i++)
         run_one(32'h8000_00F1, 5'd4, modes[i], exps[i], $sformatf("mode%0d", modes[i]));

      for (int m = 0; m < 8; m++) begin
         a = $urandom;
         run_one(a, 5'd0, 3'(m), a, $sformatf("zero_amt_m%0d", m));
      end

      run_one(32'h0000_0001, 5'd31, 3'd0, 32'h8000_0000, "sll31");
      run_one(32'h0000_0001, 5'd31, 3'd1, 32'h0000_0000, "srl31");
      run_one(32'h0000_0001, 5'd31, 3'd4, 32'h0000_0002, "ror31");
      run_one(32'h0000_0001, 5'd31, 3'd3, 32'h8000_0000, "rol31");
      run_one(32'h8000_0000, 5'd31, 3'd2, 32'hFFFF_FFFF, "sra31");
      run_one(32'h1234_5678, 5'd13, 3'd6, 32'h1234_5678, "pass_m6");

      // tags 0..9 at full rate under random backpressure
      out_ready = 1'($urandom_range(0, 1));
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1;
         in_data  = $urandom;
         in_shamt = 5'($urandom_range(0, 31));
         in_mode  = 3'($urandom_range(0, 7));
         in_tag   = 5'(i);
         fire = 1'b0;
         cnt  = 0;
         while (!fire && cnt < 50) begin
            @(negedge clock);
            fire = in_ready;
            @(posedge clock);
            #1 out_ready = 1'($urandom_range(0, 1));
            cnt++;
         end
         if (!fire) check_val("bp_accept_timeout", 32'd0, 32'd1);
      end
      drain();

      // free-running random traffic
      for (int c = 0; c < 400; c++) begin
         in_valid  = 1'($urandom_range(0, 1));
         in_data   = $urandom;
         in_shamt  = 5'($urandom_range(0, 31));
         in_mode   = 3'($urandom_range(0, 7));
         in_tag    = 5'($urandom_range(0, 31));
         out_ready = ($urandom_range(0, 3) != 0);
         @(posedge clock);
         #1;
      end
      drain();

      // bubble fill behind a stalled result
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 32'h0000_00A5;
      in_shamt  = 5'd1;
      in_mode   = 3'd0;
      in_tag    = 5'd21;
      @(posedge clock);
      #1 in_valid = 1'b0;
      cnt = 0;
      while (!out_valid && cnt < 20) begin
         @(posedge clock);
         #1 cnt++;
      end
      check_val("bubble_head", 32'(out_valid), 32'd1);
      acc = 0;
      in_valid = 1'b1;
      for (int c = 0; c < 6; c++) begin
         in_data = $urandom;
         in_tag  = 5'(22 + c);
         @(negedge clock);
         if (in_ready) acc++;
         @(posedge clock);
         #1;
      end
      check_val("bubble_accepts", 32'(acc), 32'(L - 1));
      @(negedge clock);
      check_val("bubble_full_rdy", 32'(in_ready), 32'd0);
      @(posedge clock);
      #1 drain();

      // reset with three results in flight
      out_ready = 1'b0;
      in_valid  = 1'b1;
      for (int c = 0; c < 3; c++) begin
         in_data  = $urandom;
         in_shamt = 5'($urandom_range(0, 31));
         in_mode  = 3'($urandom_range(0, 7));
         in_tag   = 5'(c + 1);
         @(posedge clock);
         #1;
      end
      in_valid = 1'b0;
      check_val("mid_full", 32'(out_valid), 32'd1);
      #2 reset_n = 1'b0;
      #1;
      check_val("mid_rst_drop", 32'(out_valid), 32'd0);
      check_val("mid_rst_data", out_data, 32'd0);
      sb.delete();
      @(negedge clock);
      @(posedge clock);
      #1 reset_n = 1'b1;
      run_one(32'h0F0F_0001, 5'd8, 3'd3, 32'h0F00_010F, "after_rst");
      extra = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clock);
         if (out_valid) extra++;
      end
      check_val("no_stale", 32'(extra), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
